// File: rtl/prio_decoder_seq.sv
// Registered N-to-2**N one-hot decoder behind a 2-entry skid FIFO with valid/ready on both sides.
// Optional DEC_HOLD_LAST_EN: out_onehot keeps the last popped value while the buffer is empty.
module prio_decoder_seq #(
    parameter int N = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N-1:0]      in_idx,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2**N-1:0]   out_onehot,
    output logic [1:0]        occupancy
);
    localparam int OW = 2**N;

    logic [N-1:0]  mem_q [2];
    logic [N-1:0]  mem_d [2];
    logic          wr_ptr_q, wr_ptr_d;
    logic          rd_ptr_q, rd_ptr_d;
    logic [1:0]    occ_q, occ_d;
    logic          push, pop;
    logic [OW-1:0] head_dec;
`ifdef DEC_HOLD_LAST_EN
    logic [OW-1:0] last_q, last_d;
`endif

    // Handshake status comes only from registered occupancy, keeping out_ready off the in_ready path.
    assign in_ready  = (occ_q != 2'd2);
    assign out_valid = (occ_q != 2'd0);
    assign occupancy = occ_q;

    always_comb begin
        head_dec = '0;
        head_dec[mem_q[rd_ptr_q]] = 1'b1;
    end

    always_comb begin
        push     = in_valid & in_ready;
        pop      = out_valid & out_ready;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q + {1'b0, push} - {1'b0, pop};
        if (push) begin
            mem_d[wr_ptr_q] = in_idx;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
    end

`ifdef DEC_HOLD_LAST_EN
    always_comb begin
        last_d = last_q;
        if (pop) begin
            last_d = head_dec;
        end
    end

    assign out_onehot = out_valid ? head_dec : last_q;
`else
    assign out_onehot = out_valid ? head_dec : '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            occ_q    <= 2'd0;
`ifdef DEC_HOLD_LAST_EN
            last_q   <= '0;
`endif
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
`ifdef DEC_HOLD_LAST_EN
            last_q   <= last_d;
`endif
        end
    end

endmodule

// File: tb/tb_prio_decoder_seq.sv
// Self-checking bench for prio_decoder_seq: directed scenarios plus random traffic against a queue model.
module tb_prio_decoder_seq;
    localparam int N  = 2;
    localparam int OW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [N-1:0]  in_idx = '0;
    logic          in_ready;
    logic          out_valid;
    logic [OW-1:0] out_onehot;
    logic [1:0]    occupancy;

    prio_decoder_seq #(.N(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_idx     (in_idx),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_onehot (out_onehot),
        .occupancy  (occupancy)
    );

    always #5 clk = ~clk;

    int q[$];
    int last_oh = 0;
    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    function automatic int exp_onehot();
        if (q.size() != 0) return 1 << q[0];
`ifdef DEC_HOLD_LAST_EN
        return last_oh;
`else
        return 0;
`endif
    endfunction

    task automatic check_model(input string tag);
        chk({tag, ".out_valid"}, int'(out_valid), int'(q.size() != 0));
        chk({tag, ".in_ready"},  int'(in_ready),  int'(q.size() != 2));
        chk({tag, ".occupancy"}, int'(occupancy), q.size());
        chk({tag, ".onehot"},    int'(out_onehot), exp_onehot());
    endtask

    // Called at a negedge: drive, advance one clock on the model, check at the next negedge.
    task automatic cyc(input bit iv, input int idx, input bit ordy, input string tag);
        bit push, pop;
        in_valid  = iv;
        in_idx    = idx[N-1:0];
        out_ready = ordy;
        push = iv && (q.size() != 2);
        pop  = ordy && (q.size() != 0);
        @(posedge clk);
        if (pop) begin
            last_oh = 1 << q[0];
            void'(q.pop_front());
        end
        if (push) q.push_back(idx);
        @(negedge clk);
        check_model(tag);
    endtask

    initial begin
        // Reset
        #1 rst_n = 1'b0;
        #2;
        chk("rst.out_valid", int'(out_valid), 0);
        chk("rst.onehot",    int'(out_onehot), 0);
        chk("rst.in_ready",  int'(in_ready), 1);
        chk("rst.occupancy", int'(occupancy), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check_model("rst");

        // Single decode
        cyc(1'b1, 3, 1'b1, "t2.push");
        chk("t2.onehot8", int'(out_onehot), 8);
        cyc(1'b0, 0, 1'b1, "t2.pop");
        chk("t2.occ0", int'(occupancy), 0);

        // Backpressure
        cyc(1'b1, 2, 1'b0, "t3.push2");
        cyc(1'b1, 1, 1'b0, "t3.push1");
        chk("t3.full_occ", int'(occupancy), 2);
        chk("t3.full_rdy", int'(in_ready), 0);
        cyc(1'b1, 0, 1'b0, "t3.hold");
        chk("t3.hold_oh", int'(out_onehot), 4);
        cyc(1'b1, 0, 1'b1, "t3.pop1");
        chk("t3.pop1_oh", int'(out_onehot), 2);
        cyc(1'b1, 0, 1'b1, "t3.pop2");
        chk("t3.pop2_oh", int'(out_onehot), 1);
        cyc(1'b0, 0, 1'b1, "t3.pop3");

        // Simultaneous push and pop
        cyc(1'b1, 1, 1'b0, "t4.fill");
        chk("t4.pre_oh", int'(out_onehot), 2);
        cyc(1'b1, 2, 1'b1, "t4.both");
        chk("t4.occ1", int'(occupancy), 1);
        chk("t4.post_oh", int'(out_onehot), 4);
        cyc(1'b0, 0, 1'b1, "t4.drain");

        // Reset mid-operation
        cyc(1'b1, 1, 1'b0, "t5.fill1");
        cyc(1'b1, 2, 1'b0, "t5.fill2");
        #2 rst_n = 1'b0;
        #1;
        chk("t5.out_valid", int'(out_valid), 0);
        chk("t5.occupancy", int'(occupancy), 0);
        chk("t5.in_ready",  int'(in_ready), 1);
        q.delete();
        last_oh = 0;
        @(negedge clk);
        rst_n = 1'b1;
        check_model("t5.rel");
        cyc(1'b1, 1, 1'b1, "t5.push");
        chk("t5.oh2", int'(out_onehot), 2);
        cyc(1'b0, 0, 1'b1, "t5.drain");

        // Empty-output behaviour after popping 4'b1000
        cyc(1'b1, 3, 1'b0, "t6.push");
        cyc(1'b0, 0, 1'b1, "t6.pop");
`ifdef DEC_HOLD_LAST_EN
        chk("t6.hold", int'(out_onehot), 8);
`else
        chk("t6.zero", int'(out_onehot), 0);
`endif

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            cyc(bit'($urandom_range(0, 3) != 0), int'($urandom_range(0, 3)),
                bit'($urandom_range(0, 2) != 0), "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
